// File: rtl/bcd_freq_counter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clk cycles as 4-digit BCD; FREQ_OVERFLOW_EN adds saturation and an overflow flag.
// Latency: edge sampled on clk N is counted on N+2; BCDfreq/valid update one cycle after LATCH, period GATE_CYCLES+1.
// Backpressure: none; en starts/continues gates and aborts a gate in progress when dropped.
module bcd_freq_counter #(
  parameter int GATE_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        sig_in,
  output logic [15:0] BCDfreq,
  output logic        valid
`ifdef FREQ_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

`ifdef FREQ_OVERFLOW_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2, sync2_prev;
  logic            edge_det;
  logic            gate_last;
  logic            counting;
  logic [GW-1:0]   gate_cnt;
  logic [15:0]     bcd_cnt;

  // Decade-carry increment; a digit at 9 rolls to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign edge_det  = sync2 & ~sync2_prev;
  assign gate_last = (gate_cnt == GATE_LAST);
  // Counting continues through the final gate cycle but not into an abort.
  assign counting  = (state == COUNT) && (state_nxt != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_prev <= 1'b0;
    end else begin
      sync1      <= sig_in;
      sync2      <= sync1;
      sync2_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = COUNT;
      COUNT: begin
        if (!en)            state_nxt = IDLE;
        else if (gate_last) state_nxt = LATCH;
      end
      LATCH:   state_nxt = en ? COUNT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_cnt <= '0;
      bcd_cnt  <= '0;
      BCDfreq  <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= (state == LATCH);
      if (state == LATCH) BCDfreq <= bcd_cnt;

      if ((state == COUNT) && (state_nxt == COUNT)) gate_cnt <= gate_cnt + 1'b1;
      else                                          gate_cnt <= '0;

      if (counting) begin
        if (edge_det && !(SATURATE && (bcd_cnt == 16'h9999))) bcd_cnt <= bcd_inc(bcd_cnt);
      end else begin
        bcd_cnt <= '0;
      end
    end
  end

`ifdef FREQ_OVERFLOW_EN
  logic ovf_flag;

  // Sticky for the current gate; published together with BCDfreq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == LATCH) overflow <= ovf_flag;
      if (counting) begin
        if (edge_det && (bcd_cnt == 16'h9999)) ovf_flag <= 1'b1;
      end else begin
        ovf_flag <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bcd_freq_counter.sv
// Randomized bench for bcd_freq_counter: a short-gate instance for gating/abort/reset behaviour
// and a 30000-cycle instance for digit carries and the 9999 boundary.
module tb_bcd_freq_counter;

  localparam int GA = 100;
  localparam int GB = 30000;

  logic        clk;
  logic        reset;
  logic        en_a, sig_a, en_b, sig_b;
  logic [15:0] freq_a, freq_b;
  logic        valid_a, valid_b;
`ifdef FREQ_OVERFLOW_EN
  logic        ovf_a, ovf_b;
`endif

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_freq_a = 16'h0000;
  logic        pv_a = 1'b0;
  logic        pv_b = 1'b0;

  bcd_freq_counter #(.GATE_CYCLES(GA)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .sig_in(sig_a),
    .BCDfreq(freq_a), .valid(valid_a)
`ifdef FREQ_OVERFLOW_EN
    , .overflow(ovf_a)
`endif
  );

  bcd_freq_counter #(.GATE_CYCLES(GB)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .sig_in(sig_b),
    .BCDfreq(freq_b), .valid(valid_b)
`ifdef FREQ_OVERFLOW_EN
    , .overflow(ovf_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // valid must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (reset) begin
      if (valid_a) check("valid_a_twice", pv_a, 0);
      if (valid_b) check("valid_b_twice", pv_b, 0);
    end
    pv_a = valid_a;
    pv_b = valid_b;
  end

  // One gate on instance A from IDLE. per==0 gives random bits, else a square wave.
  // The model counts 0->1 transitions among the sig values sampled on the gate's
  // first GA-1 clk edges (earlier history is zero), i.e. those that land inside COUNT.
  task automatic gate_a(input int per, input int phase, input int abort_at, input bit rel);
    logic w [0:GA+1];
    int   dens, edges;
    logic prev;
    bit   done;
    dens = $urandom_range(10, 90);
    for (int c = 0; c <= GA + 1; c++)
      w[c] = (per == 0) ? ($urandom_range(0, 99) < dens) : (((c + phase) % per) < (per / 2));
    prev  = 1'b0;
    edges = 0;
    for (int c = 0; c <= GA - 2; c++) begin
      if (w[c] && !prev) edges++;
      prev = w[c];
    end
    done  = (abort_at < 0);
    sig_a = 1'b0;
    en_a  = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c <= GA + 1; c++) begin
      sig_a = w[c];
      en_a  = (c <= GA) && (abort_at < 0 || c < abort_at);
      if (rel) reset = 1'b1;
      @(negedge clk);
      check("valid_a", valid_a, done && (c == GA + 1));
    end
    if (done) exp_freq_a = to_bcd(edges);
    check("freq_a", freq_a, exp_freq_a);
`ifdef FREQ_OVERFLOW_EN
    check("ovf_a", ovf_a, 0);
`endif
  endtask

  // Three back-to-back gates with en held high and a period-4 signal.
  task automatic cont_a();
    int t;
    t    = 0;
    en_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sig_a = (t % 4) < 2;
      t++;
      @(negedge clk);
    end
    for (int c = 0; c <= 3 * (GA + 1); c++) begin
      sig_a = (t % 4) < 2;
      t++;
      en_a  = (c < 3 * (GA + 1));
      @(negedge clk);
      check("cont_valid", valid_a, (c > 0) && (c % (GA + 1) == 0));
      if ((c > 0) && (c % (GA + 1) == 0)) check("cont_freq", freq_a, 16'h0025);
    end
    exp_freq_a = 16'h0025;
  endtask

  task automatic reset_test();
    en_a = 1'b1;
    for (int c = 0; c < 40; c++) begin
      sig_a = (c % 4) < 2;
      @(negedge clk);
      check("pre_rst_valid", valid_a, 0);
    end
    #1 reset = 1'b0;
    #1;
    check("rst_freq_a", freq_a, 16'h0000);
    check("rst_valid_a", valid_a, 0);
    exp_freq_a = 16'h0000;
    gate_a(4, 0, -1, 1'b1);
  endtask

  task automatic b_tests();
    logic [15:0] bc;
    bit          ok;
    sig_b = 1'b0;
    en_b  = 1'b0;
    repeat (4) @(negedge clk);
    // exactly 1099 pulses well inside the gate
    for (int c = 0; c <= GB + 1; c++) begin
      sig_b = (c >= 10 && c < 10 + 4 * 1099) ? ((c - 10) % 4 < 2) : 1'b0;
      en_b  = (c <= GB);
      @(negedge clk);
      bc = dut_b.bcd_cnt;
      ok = (bc[3:0] <= 4'd9) && (bc[7:4] <= 4'd9) && (bc[11:8] <= 4'd9) && (bc[15:12] <= 4'd9);
      check("digits_b", ok, 1);
      check("valid_b", valid_b, c == GB + 1);
    end
    check("freq_1099", freq_b, 16'h1099);
`ifdef FREQ_OVERFLOW_EN
    check("ovf_1099", ovf_b, 0);
`endif
    // 15000 edges: alternate every cycle
    en_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sig_b = ~sig_b;
      @(negedge clk);
    end
    for (int c = 0; c <= GB + 1; c++) begin
      sig_b = ~sig_b;
      en_b  = (c <= GB);
      @(negedge clk);
      check("valid_b15k", valid_b, c == GB + 1);
    end
`ifdef FREQ_OVERFLOW_EN
    check("freq_15000", freq_b, 16'h9999);
    check("ovf_15000", ovf_b, 1);
`else
    check("freq_15000", freq_b, 16'h5000);
`endif
  endtask

  initial begin
    reset = 1'b0;
    en_a  = 1'b0;
    sig_a = 1'b0;
    en_b  = 1'b0;
    sig_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_freq_a", freq_a, 16'h0000);
    check("reset_valid_a", valid_a, 0);
    check("reset_freq_b", freq_b, 16'h0000);
    check("reset_valid_b", valid_b, 0);
`ifdef FREQ_OVERFLOW_EN
    check("reset_ovf_a", ovf_a, 0);
`endif
    reset = 1'b1;

    // en low: sig activity must not produce a measurement
    for (int c = 0; c < 300; c++) begin
      sig_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_valid", valid_a, 0);
    end
    check("idle_freq", freq_a, 16'h0000);

    for (int i = 0; i < 6; i++) gate_a(0, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) gate_a($urandom_range(2, 9), $urandom_range(0, 8), -1, 1'b0);

    cont_a();

    gate_a(10, 0, 50, 1'b0);
    check("abort_keeps", freq_a, 16'h0025);
    gate_a(10, 0, -1, 1'b0);
    check("after_abort", freq_a, 16'h0010);

    reset_test();
    b_tests();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
